// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: data width, access size codes,
// FSM state encoding and the alignment rule for a byte address offset.
// No logic; imported by load_store_unit and lsu_lane_align.
package lsu_pkg;

  localparam int DATA_W = 32;

  // Access size codes as presented on Size; 2'b11 is reserved and handled as a word.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_DONE = 2'b11
  } lsu_state_t;

  // Halfwords need an even offset; words (and the reserved code) need offset 0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = offset[0];
      default: mis = (offset != 2'b00);
    endcase
    return mis;
  endfunction

  function automatic logic is_sub_word(input logic [1:0] size);
    return (size == SZ_BYTE) || (size == SZ_HALF);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Big-endian byte-lane steering: extracts a load lane from a RAM word and merges store data into one.
// Purely combinational, zero latency; no handshake.
// Ports: word/offset/size/sign_ext/wr_data in; load_val (right-justified, extended) and merged_word out.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        offset,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] load_val,
  output logic [DATA_W-1:0] merged_word
);

  // Big-endian: byte offset k sits 8*(3-k) bits up, and ~k == 3-k for 2-bit k.
  // Halfword offset 0 is the upper half, offset 2 the lower half.
  logic [4:0]        byte_shamt;
  logic [4:0]        half_shamt;
  logic [DATA_W-1:0] lane;
  logic              ext_bit;

  always_comb begin
    byte_shamt  = {~offset, 3'b000};
    half_shamt  = {~offset[1], 4'b0000};
    lane        = '0;
    ext_bit     = 1'b0;
    load_val    = word;
    merged_word = wr_data;
    case (size)
      SZ_BYTE: begin
        lane        = word >> byte_shamt;
        ext_bit     = sign_ext & lane[7];
        load_val    = {{24{ext_bit}}, lane[7:0]};
        merged_word = (word & ~(32'h0000_00FF << byte_shamt))
                    | ({24'h0, wr_data[7:0]} << byte_shamt);
      end
      SZ_HALF: begin
        lane        = word >> half_shamt;
        ext_bit     = sign_ext & lane[15];
        load_val    = {{16{ext_bit}}, lane[15:0]};
        merged_word = (word & ~(32'h0000_FFFF << half_shamt))
                    | ({16'h0, wr_data[15:0]} << half_shamt);
      end
      default: begin
        load_val    = word;
        merged_word = wr_data;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// DataRAM initiator serving byte/half/word loads and stores; sub-word stores run as read-modify-write.
// Latency from accept edge to Done: misaligned 1, load or word store 2, sub-word store 3 cycles.
// Req is sampled only in IDLE (Busy low); Req during an access is ignored, never queued.
// Ports: Clk/Reset; Req/Wr/Size/SignExt/ByteAddr/WrData request; Busy/Done/Misaligned/RdData status;
//        RamAddr/RamDataIn/RamMemWr/RamDataOut to the word-wide DataRAM.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WORD_ADDR_W = 5
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Req,
  input  logic                   Wr,
  input  logic [1:0]             Size,
  input  logic                   SignExt,
  input  logic [WORD_ADDR_W+1:0] ByteAddr,
  input  logic [DATA_W-1:0]      WrData,
  output logic                   Busy,
  output logic                   Done,
  output logic                   Misaligned,
  output logic [DATA_W-1:0]      RdData,
  output logic [WORD_ADDR_W-1:0] RamAddr,
  output logic [DATA_W-1:0]      RamDataIn,
  output logic                   RamMemWr,
  input  logic [DATA_W-1:0]      RamDataOut
);

  lsu_state_t             state_q, state_d;
  logic                   wr_q, wr_d;
  logic [1:0]             size_q, size_d;
  logic                   sext_q, sext_d;
  logic [1:0]             off_q, off_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic                   mis_q, mis_d;
  logic [DATA_W-1:0]      rd_data_q, rd_data_d;
  logic [WORD_ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]      ram_din_q, ram_din_d;

  logic [DATA_W-1:0]      load_val;
  logic [DATA_W-1:0]      merged_word;
  logic                   req_mis;

  // Lane steering always works on the live RAM word and the latched request.
  lsu_lane_align u_lane_align (
    .word        (RamDataOut),
    .offset      (off_q),
    .size        (size_q),
    .sign_ext    (sext_q),
    .wr_data     (wdata_q),
    .load_val    (load_val),
    .merged_word (merged_word)
  );

  assign req_mis = is_misaligned(Size, ByteAddr[1:0]);

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    size_d     = size_q;
    sext_d     = sext_q;
    off_d      = off_q;
    wdata_d    = wdata_q;
    mis_d      = mis_q;
    rd_data_d  = rd_data_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;

    case (state_q)
      ST_IDLE: begin
        if (Req) begin
          wr_d    = Wr;
          size_d  = Size;
          sext_d  = SignExt;
          off_d   = ByteAddr[1:0];
          wdata_d = WrData;
          mis_d   = req_mis;
          if (req_mis) begin
            // Rejected: no RAM cycle, RamAddr keeps its previous value.
            state_d = ST_DONE;
          end else begin
            ram_addr_d = ByteAddr[WORD_ADDR_W+1:2];
            if (Wr && !is_sub_word(Size)) begin
              ram_din_d = WrData;
              state_d   = ST_WR;
            end else begin
              // Loads and sub-word stores both need the current RAM word first.
              state_d = ST_RD;
            end
          end
        end
      end
      ST_RD: begin
        if (wr_q) begin
          ram_din_d = merged_word;
          state_d   = ST_WR;
        end else begin
          rd_data_d = load_val;
          state_d   = ST_DONE;
        end
      end
      ST_WR:   state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      wr_q       <= 1'b0;
      size_q     <= SZ_BYTE;
      sext_q     <= 1'b0;
      off_q      <= 2'b00;
      wdata_q    <= '0;
      mis_q      <= 1'b0;
      rd_data_q  <= '0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      size_q     <= size_d;
      sext_q     <= sext_d;
      off_q      <= off_d;
      wdata_q    <= wdata_d;
      mis_q      <= mis_d;
      rd_data_q  <= rd_data_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
    end
  end

  assign Busy       = (state_q != ST_IDLE);
  assign Done       = (state_q == ST_DONE);
  assign Misaligned = (state_q == ST_DONE) && mis_q;
  assign RdData     = rd_data_q;
  assign RamAddr    = ram_addr_q;
  assign RamDataIn  = ram_din_q;
  // Gated by Reset so an access aborted in its write cycle never commits.
  assign RamMemWr   = (state_q == ST_WR) && !Reset;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic        sext;
  logic [6:0]  baddr;
  logic [31:0] wdata;
  logic        busy, done, mis_o, ram_we;
  logic [31:0] rd_data, ram_din, ram_dout;
  logic [4:0]  ram_addr;

  int checks = 0;
  int fails  = 0;

  logic [31:0] mem     [32];
  logic [31:0] ref_mem [32];
  logic [31:0] exp_rd;

  always #5 clk = ~clk;

  load_store_unit #(.WORD_ADDR_W(5)) dut (
    .Clk(clk), .Reset(rst), .Req(req), .Wr(wr), .Size(size), .SignExt(sext),
    .ByteAddr(baddr), .WrData(wdata), .Busy(busy), .Done(done),
    .Misaligned(mis_o), .RdData(rd_data), .RamAddr(ram_addr),
    .RamDataIn(ram_din), .RamMemWr(ram_we), .RamDataOut(ram_dout)
  );

  // DataRAM: combinational read, synchronous write.
  assign ram_dout = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_din;

  // ---------------- reference model (arithmetic on byte counts) ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic model_mis(input logic [1:0] sz, input logic [6:0] a);
    return (int'(a) % nbytes(sz)) != 0;
  endfunction

  function automatic int model_lat(input logic w, input logic [1:0] sz, input logic [6:0] a);
    if (model_mis(sz, a)) return 1;
    if (w && nbytes(sz) < 4) return 3;
    return 2;
  endfunction

  // Lane position from the big-endian rule: the lane ends (4-off-n) bytes above bit 0.
  function automatic logic [31:0] model_load(input logic [31:0] w32, input logic [1:0] sz,
                                             input logic sx, input int off);
    int n;
    logic [31:0] mask, v;
    n = nbytes(sz);
    if (n == 4) return w32;
    mask = (32'd1 << (8 * n)) - 32'd1;
    v = (w32 >> (8 * (4 - off - n))) & mask;
    if (sx && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w32, input logic [1:0] sz,
                                              input int off, input logic [31:0] d);
    int n, sh;
    logic [31:0] mask;
    n = nbytes(sz);
    if (n == 4) return d;
    mask = (32'd1 << (8 * n)) - 32'd1;
    sh = 8 * (4 - off - n);
    return (w32 & ~(mask << sh)) | ((d & mask) << sh);
  endfunction

  // ---------------- stimulus driver (observation only, no checks) ----------------
  task automatic do_access(input logic w, input logic [1:0] sz, input logic sx,
                           input logic [6:0] a, input logic [31:0] d,
                           output int lat, output logic mis, output int wr_cnt,
                           output logic [4:0] wr_a, output logic [31:0] wr_d,
                           output int rd_cnt, output logic [31:0] rd);
    lat = 0; mis = 1'b0; wr_cnt = 0; wr_a = '0; wr_d = '0; rd_cnt = 0; rd = '0;
    @(negedge clk);
    req = 1'b1; wr = w; size = sz; sext = sx; baddr = a; wdata = d;
    @(posedge clk);
    #1 req = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ram_we) begin
        wr_cnt++; wr_a = ram_addr; wr_d = ram_din;
      end else if (busy && !done) begin
        rd_cnt++;
      end
      if (done) begin
        lat = k; mis = mis_o; rd = rd_data;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd0; sext = 1'b0; baddr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, mis_o, ram_we} !== 4'b0000) begin
      fails++; $display("FAIL reset_ctrl: busy/done/mis/we=%b expected 0000", {busy, done, mis_o, ram_we});
    end
    checks++;
    if (rd_data !== 32'h0 || ram_addr !== 5'h0 || ram_din !== 32'h0) begin
      fails++; $display("FAIL reset_data: rd=%h addr=%h din=%h expected zeros", rd_data, ram_addr, ram_din);
    end
    rst = 1'b0;
    exp_rd = 32'h0;
  endtask

  task automatic test_word_store_load();
    int lat, wc, rc; logic m; logic [4:0] wa; logic [31:0] wd, rd;
    do_access(1'b1, 2'd2, 1'b0, 7'h0C, 32'hDEADBEEF, lat, m, wc, wa, wd, rc, rd);
    checks++;
    if (lat !== 2 || m !== 1'b0) begin
      fails++; $display("FAIL sw_latency: lat=%0d mis=%b expected lat=2 mis=0", lat, m);
    end
    checks++;
    if (wc !== 1 || wa !== 5'd3 || wd !== 32'hDEADBEEF) begin
      fails++; $display("FAIL sw_write: count=%0d addr=%0d data=%h expected 1/3/deadbeef", wc, wa, wd);
    end
    ref_mem[3] = 32'hDEADBEEF;
    do_access(1'b0, 2'd2, 1'b0, 7'h0C, 32'h0, lat, m, wc, wa, wd, rc, rd);
    checks++;
    if (lat !== 2 || rd !== 32'hDEADBEEF || wc !== 0) begin
      fails++; $display("FAIL lw_readback: lat=%0d rd=%h writes=%0d expected 2/deadbeef/0", lat, rd, wc);
    end
    exp_rd = 32'hDEADBEEF;
  endtask

  task automatic test_byte_rmw();
    int lat, wc, rc; logic m; logic [4:0] wa; logic [31:0] wd, rd;
    mem[5] = 32'h11223344; ref_mem[5] = 32'h11223344;
    do_access(1'b1, 2'd0, 1'b0, 7'h15, 32'h000000AA, lat, m, wc, wa, wd, rc, rd);
    checks++;
    if (lat !== 3 || rc !== 1 || wc !== 1) begin
      fails++; $display("FAIL sb_sequence: lat=%0d rd_cycles=%0d wr_cycles=%0d expected 3/1/1", lat, rc, wc);
    end
    checks++;
    if (wa !== 5'd5 || wd !== 32'h11AA3344) begin
      fails++; $display("FAIL sb_merge: addr=%0d data=%h expected 5/11aa3344", wa, wd);
    end
    ref_mem[5] = 32'h11AA3344;
  endtask

  task automatic test_sub_loads();
    int lat, wc, rc; logic m; logic [4:0] wa; logic [31:0] wd, rd;
    mem[2] = 32'h80FF7F01; ref_mem[2] = 32'h80FF7F01;
    do_access(1'b0, 2'd0, 1'b1, 7'h08, 32'h0, lat, m, wc, wa, wd, rc, rd);
    checks++;
    if (rd !== 32'hFFFFFF80 || lat !== 2) begin
      fails++; $display("FAIL lb_signed: rd=%h lat=%0d expected ffffff80/2", rd, lat);
    end
    do_access(1'b0, 2'd0, 1'b0, 7'h0A, 32'h0, lat, m, wc, wa, wd, rc, rd);
    checks++;
    if (rd !== 32'h0000007F) begin
      fails++; $display("FAIL lbu: rd=%h expected 0000007f", rd);
    end
    do_access(1'b0, 2'd1, 1'b1, 7'h0A, 32'h0, lat, m, wc, wa, wd, rc, rd);
    checks++;
    if (rd !== 32'h00007F01) begin
      fails++; $display("FAIL lh_signed: rd=%h expected 00007f01", rd);
    end
    exp_rd = 32'h00007F01;
  endtask

  task automatic test_misaligned();
    int lat, wc, rc; logic m; logic [4:0] wa; logic [31:0] wd, rd;
    do_access(1'b0, 2'd2, 1'b0, 7'h06, 32'h0, lat, m, wc, wa, wd, rc, rd);
    checks++;
    if (lat !== 1 || m !== 1'b1 || rc !== 0 || wc !== 0 || rd !== exp_rd) begin
      fails++; $display("FAIL lw_misaligned: lat=%0d mis=%b rd_cyc=%0d wr_cyc=%0d rd=%h expected 1/1/0/0/%h",
                        lat, m, rc, wc, rd, exp_rd);
    end
    do_access(1'b1, 2'd1, 1'b0, 7'h03, 32'h1234, lat, m, wc, wa, wd, rc, rd);
    checks++;
    if (lat !== 1 || m !== 1'b1 || rc !== 0 || wc !== 0) begin
      fails++; $display("FAIL sh_misaligned: lat=%0d mis=%b rd_cyc=%0d wr_cyc=%0d expected 1/1/0/0", lat, m, rc, wc);
    end
  endtask

  task automatic test_reset_during_wr();
    int lat, wc, rc, done_seen; logic m; logic [4:0] wa; logic [31:0] wd, rd;
    mem[0] = 32'hCAFEF00D; ref_mem[0] = 32'hCAFEF00D;
    @(negedge clk);
    req = 1'b1; wr = 1'b1; size = 2'd0; sext = 1'b0; baddr = 7'h01; wdata = 32'h5A;
    @(posedge clk);           // accept
    #1 req = 1'b0;
    @(posedge clk);           // RD -> WR
    #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ram_we !== 1'b0) begin
      fails++; $display("FAIL rst_we_gate: RamMemWr=%b expected 0", ram_we);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || rd_data !== 32'h0) begin
      fails++; $display("FAIL rst_abort: busy=%b done=%b rd=%h expected 0/0/0", busy, done, rd_data);
    end
    done_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      fails++; $display("FAIL rst_no_done: done pulses=%0d expected 0", done_seen);
    end
    exp_rd = 32'h0;
    do_access(1'b0, 2'd2, 1'b0, 7'h00, 32'h0, lat, m, wc, wa, wd, rc, rd);
    checks++;
    if (rd !== ref_mem[0]) begin
      fails++; $display("FAIL rst_ram_intact: rd=%h expected %h", rd, ref_mem[0]);
    end
    exp_rd = ref_mem[0];
  endtask

  task automatic test_back_to_back();
    int t, first_done, second_done; logic idle_gap;
    first_done = -1; second_done = -1; idle_gap = 1'b0;
    @(negedge clk);
    req = 1'b1; wr = 1'b1; size = 2'd2; sext = 1'b0; baddr = 7'h7C; wdata = 32'hA5C3_0F96;
    for (t = 0; t < 20 && second_done < 0; t++) begin
      @(negedge clk);
      if (first_done >= 0 && t == first_done + 1) idle_gap = !busy;
      if (first_done >= 0 && t == first_done + 2) req = 1'b0;
      if (done && first_done < 0) begin
        first_done = t;
        wr = 1'b0; wdata = 32'h0;   // Req stays high: next access is the load
      end else if (done && first_done >= 0) begin
        second_done = t;
      end
    end
    req = 1'b0;
    checks++;
    if (!idle_gap || first_done < 0 || second_done - first_done !== 3) begin
      fails++; $display("FAIL b2b_spacing: first=%0d second=%0d idle_gap=%b expected gap of 3 with idle", first_done, second_done, idle_gap);
    end
    checks++;
    if (rd_data !== 32'hA5C3_0F96) begin
      fails++; $display("FAIL b2b_top_addr: rd=%h expected a5c30f96", rd_data);
    end
    ref_mem[31] = 32'hA5C3_0F96;
    exp_rd = 32'hA5C3_0F96;
  endtask

  task automatic test_random();
    int lat, wc, rc, elat; logic m, emis; logic [4:0] wa; logic [31:0] wd, rd, ew;
    logic w, sx; logic [1:0] sz; logic [6:0] a; logic [31:0] d;
    for (int i = 0; i < 80; i++) begin
      w = 1'($urandom); sx = 1'($urandom); sz = 2'($urandom);
      a = 7'($urandom); d = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00 | (a[1:0] & ((sz == 2'd0) ? 2'b11 : (sz == 2'd1) ? 2'b10 : 2'b00));
      emis = model_mis(sz, a);
      elat = model_lat(w, sz, a);
      do_access(w, sz, sx, a, d, lat, m, wc, wa, wd, rc, rd);
      checks++;
      if (lat !== elat || m !== emis) begin
        fails++; $display("FAIL rand_timing[%0d]: lat=%0d mis=%b expected %0d/%b", i, lat, m, elat, emis);
      end
      if (!emis && w) begin
        ew = model_store(ref_mem[a[6:2]], sz, int'(a[1:0]), d);
        ref_mem[a[6:2]] = ew;
        checks++;
        if (wc !== 1 || wa !== a[6:2] || wd !== ew) begin
          fails++; $display("FAIL rand_store[%0d]: cnt=%0d addr=%0d data=%h expected 1/%0d/%h", i, wc, wa, wd, a[6:2], ew);
        end
      end else begin
        if (!emis) exp_rd = model_load(ref_mem[a[6:2]], sz, sx, int'(a[1:0]));
        checks++;
        if (wc !== 0 || rd !== exp_rd) begin
          fails++; $display("FAIL rand_load[%0d]: writes=%0d rd=%h expected 0/%h", i, wc, rd, exp_rd);
        end
      end
    end
    for (int j = 0; j < 32; j++) begin
      checks++;
      if (mem[j] !== ref_mem[j]) begin
        fails++; $display("FAIL rand_ram[%0d]: %h expected %h", j, mem[j], ref_mem[j]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    exp_rd = 32'h0;
    test_reset();
    test_word_store_load();
    test_byte_rmw();
    test_sub_loads();
    test_misaligned();
    test_reset_during_wr();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
